sample_iterator: RTL and testbench

- Rasterizer stage directly downstream of the bounding-box stage and upstream of the sample-hash/sample-test stages.
- Accepts one triangle at a time with its subsample-snapped bounding box.
- Walks every subsample position inside the box in raster order (x fastest), emitting one sample per cycle with the triangle and color attached.
- Stalls upstream through an active-low halt while a box is being walked.

---
 rtl/sample_iterator_pkg.sv | 31 +++
 rtl/sample_step_gen.sv | 21 ++
 rtl/sample_iterator.sv | 134 +++++++++++++
 tb/tb_sample_iterator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sample_iterator_pkg.sv
// Shared rasterizer parameters and types for the sample iterator stage.
//   SIGFIG/RADIX : fixed-point word width and fraction bits
//   VERTS/AXIS/COLORS : triangle and color geometry
//   iter_state_t : walker FSM states
//   LL/UR/X/Y    : indices into the packed box {ur_y, ur_x, ll_y, ll_x}
//   SS_*         : one-hot subsample rate encodings
package sample_iterator_pkg;

    localparam int unsigned SIGFIG = 24;
    localparam int unsigned RADIX  = 10;
    localparam int unsigned VERTS  = 3;
    localparam int unsigned AXIS   = 3;
    localparam int unsigned COLORS = 3;

    typedef enum logic {
        WAIT_STATE,
        TEST_STATE
    } iter_state_t;

    // Box is viewed as [corner][axis][SIGFIG-1:0]; corner 1 / axis 1 sit in the MSBs.
    localparam int unsigned LL = 0;
    localparam int unsigned UR = 1;
    localparam int unsigned X  = 0;
    localparam int unsigned Y  = 1;

    localparam logic [3:0] SS_1X  = 4'b1000;
    localparam logic [3:0] SS_4X  = 4'b0100;
    localparam logic [3:0] SS_16X = 4'b0010;
    localparam logic [3:0] SS_64X = 4'b0001;

endpackage

// File: rtl/sample_step_gen.sv
// Subsample step decoder.
//   sub_sample_i : one-hot sample rate (SS_1X/SS_4X/SS_16X/SS_64X)
//   step_o       : distance between adjacent subsamples in RADIX fixed point
// Any encoding that is not one-hot falls back to the 1spp step.
module sample_step_gen
    import sample_iterator_pkg::*;
(
    input  logic [3:0]        sub_sample_i,
    output logic [SIGFIG-1:0] step_o
);

    always_comb begin
        case (sub_sample_i)
            SS_4X:   step_o = SIGFIG'(1) << (RADIX - 1);
            SS_16X:  step_o = SIGFIG'(1) << (RADIX - 2);
            SS_64X:  step_o = SIGFIG'(1) << (RADIX - 3);
            default: step_o = SIGFIG'(1) << RADIX;
        endcase
    end

endmodule

// File: rtl/sample_iterator.sv
// Sample iterator: walks every subsample position of a triangle's bounding
// box in raster order (x fastest), one sample per cycle.
//   clk, rst          : clock, synchronous active-high reset
//   tri_R13S          : triangle vertices in
//   color_R13U        : triangle color in
//   box_R13S          : {ur_y, ur_x, ll_y, ll_x}, snapped to the subsample grid
//   validTri_R13H     : triangle/box valid (accepted only while idle)
//   subSample_RnnnnU  : one-hot sample rate, sampled on acceptance
//   tri_R14S, color_R14U : latched triangle and color
//   sample_R14S       : {y, x} current sample position
//   validSamp_R14H    : sample valid
//   halt_RnnnnL       : low while a box is being walked (upstream must hold)
module sample_iterator
    import sample_iterator_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [VERTS*AXIS*SIGFIG-1:0]  tri_R13S,
    input  logic [COLORS*SIGFIG-1:0]      color_R13U,
    input  logic [4*SIGFIG-1:0]           box_R13S,
    input  logic                          validTri_R13H,
    input  logic [3:0]                    subSample_RnnnnU,
    output logic [VERTS*AXIS*SIGFIG-1:0]  tri_R14S,
    output logic [COLORS*SIGFIG-1:0]      color_R14U,
    output logic [2*SIGFIG-1:0]           sample_R14S,
    output logic                          validSamp_R14H,
    output logic                          halt_RnnnnL
);

    iter_state_t                          state_q, state_d;
    logic [VERTS*AXIS*SIGFIG-1:0]         tri_q, tri_d;
    logic [COLORS*SIGFIG-1:0]             color_q, color_d;
    logic [1:0][1:0][SIGFIG-1:0]          box_q, box_d;
    logic [SIGFIG-1:0]                    step_q, step_d;
    logic [1:0][SIGFIG-1:0]               sample_q, sample_d;
    logic                                 valid_q, valid_d;
    logic                                 halt_q, halt_d;

    logic [1:0][1:0][SIGFIG-1:0]          box_in;
    logic [SIGFIG-1:0]                    step_w;

    // One extra bit so a step past the top of the signed range cannot wrap
    // around and compare as "<= ur".
    logic signed [SIGFIG:0]               x_next, y_next, ur_x_ext, ur_y_ext;

    assign box_in = box_R13S;

    sample_step_gen u_step_gen (
        .sub_sample_i (subSample_RnnnnU),
        .step_o       (step_w)
    );

    always_comb begin
        x_next   = {sample_q[X][SIGFIG-1], sample_q[X]} + {1'b0, step_q};
        y_next   = {sample_q[Y][SIGFIG-1], sample_q[Y]} + {1'b0, step_q};
        ur_x_ext = {box_q[UR][X][SIGFIG-1], box_q[UR][X]};
        ur_y_ext = {box_q[UR][Y][SIGFIG-1], box_q[UR][Y]};
    end

    always_comb begin
        state_d  = state_q;
        tri_d    = tri_q;
        color_d  = color_q;
        box_d    = box_q;
        step_d   = step_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        halt_d   = halt_q;

        case (state_q)
            WAIT_STATE: begin
                valid_d = 1'b0;
                halt_d  = 1'b1;
                if (validTri_R13H) begin
                    tri_d       = tri_R13S;
                    color_d     = color_R13U;
                    box_d       = box_in;
                    step_d      = step_w;
                    sample_d[X] = box_in[LL][X];
                    sample_d[Y] = box_in[LL][Y];
                    valid_d     = 1'b1;
                    halt_d      = 1'b0;
                    state_d     = TEST_STATE;
                end
            end
            TEST_STATE: begin
                if (x_next <= ur_x_ext) begin
                    sample_d[X] = x_next[SIGFIG-1:0];
                end else if (y_next <= ur_y_ext) begin
                    sample_d[X] = box_q[LL][X];
                    sample_d[Y] = y_next[SIGFIG-1:0];
                end else begin
                    valid_d = 1'b0;
                    halt_d  = 1'b1;
                    state_d = WAIT_STATE;
                end
            end
            default: begin
                valid_d = 1'b0;
                halt_d  = 1'b1;
                state_d = WAIT_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_STATE;
            tri_q    <= '0;
            color_q  <= '0;
            box_q    <= '0;
            step_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            halt_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            box_q    <= box_d;
            step_q   <= step_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            halt_q   <= halt_d;
        end
    end

    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = sample_q;
    assign validSamp_R14H = valid_q;
    assign halt_RnnnnL    = halt_q;

endmodule

// File: tb/tb_sample_iterator.sv
module tb_sample_iterator;
    import sample_iterator_pkg::*;

    logic                          clk;
    logic                          rst;
    logic [VERTS*AXIS*SIGFIG-1:0]  tri_in;
    logic [COLORS*SIGFIG-1:0]      color_in;
    logic [4*SIGFIG-1:0]           box_in;
    logic                          valid_tri;
    logic [3:0]                    sub_sample;
    logic [VERTS*AXIS*SIGFIG-1:0]  tri_out;
    logic [COLORS*SIGFIG-1:0]      color_out;
    logic [2*SIGFIG-1:0]           sample_out;
    logic                          valid_samp;
    logic                          halt;

    int tests = 0;
    int fails = 0;

    logic [23:0]  exp_x[$];
    logic [23:0]  exp_y[$];
    logic [215:0] exp_tri;
    logic [71:0]  exp_color;

    localparam logic [215:0] TRI_A = {9{24'h123456}};
    localparam logic [215:0] TRI_B = {9{24'h654321}};
    localparam logic [215:0] TRI_C = {9{24'h0F0F0F}};
    localparam logic [71:0]  COL_A = {3{24'h00ABCD}};
    localparam logic [71:0]  COL_B = {3{24'h7700EE}};
    localparam logic [71:0]  COL_C = {3{24'h111111}};

    sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_tri),
        .subSample_RnnnnU (sub_sample),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .sample_R14S      (sample_out),
        .validSamp_R14H   (valid_samp),
        .halt_RnnnnL      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [23:0] x, input logic [23:0] y);
        exp_x.push_back(x);
        exp_y.push_back(y);
    endtask

    // Present a triangle at a negedge; it is accepted at the next posedge.
    task automatic send(input logic [23:0] llx, input logic [23:0] lly,
                        input logic [23:0] urx, input logic [23:0] ury,
                        input logic [3:0] ss, input logic [215:0] t,
                        input logic [71:0] c, input bit hold);
        box_in     = {ury, urx, lly, llx};
        sub_sample = ss;
        tri_in     = t;
        color_in   = c;
        valid_tri  = 1'b1;
        exp_tri    = t;
        exp_color  = c;
        @(negedge clk);
        if (!hold) valid_tri = 1'b0;
    endtask

    // Checks every queued sample in consecutive cycles, then the bubble.
    task automatic check_walk(input string tag);
        for (int i = 0; i < exp_x.size(); i++) begin
            chk($sformatf("%s_valid%0d", tag, i), valid_samp, 1'b1);
            chk($sformatf("%s_halt%0d", tag, i), halt, 1'b0);
            chk($sformatf("%s_x%0d", tag, i), sample_out[23:0], exp_x[i]);
            chk($sformatf("%s_y%0d", tag, i), sample_out[47:24], exp_y[i]);
            chk($sformatf("%s_tri%0d", tag, i), tri_out, exp_tri);
            chk($sformatf("%s_color%0d", tag, i), color_out, exp_color);
            @(negedge clk);
        end
        chk($sformatf("%s_end_valid", tag), valid_samp, 1'b0);
        chk($sformatf("%s_end_halt", tag), halt, 1'b1);
        exp_x.delete();
        exp_y.delete();
    endtask

    initial begin
        rst        = 1'b1;
        tri_in     = '0;
        color_in   = '0;
        box_in     = '0;
        valid_tri  = 1'b0;
        sub_sample = SS_1X;
        exp_tri    = '0;
        exp_color  = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid", valid_samp, 1'b0);
        chk("rst_halt", halt, 1'b1);
        chk("rst_sample", sample_out, 48'h0);
        chk("rst_tri", tri_out, 216'h0);
        chk("rst_color", color_out, 72'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_valid", valid_samp, 1'b0);
        chk("idle_halt", halt, 1'b1);

        // 1: 1spp 3x2 box
        send(24'd0, 24'd0, 24'd2048, 24'd1024, SS_1X, TRI_A, COL_A, 1'b0);
        exp_push(24'd0, 24'd0);    exp_push(24'd1024, 24'd0);    exp_push(24'd2048, 24'd0);
        exp_push(24'd0, 24'd1024); exp_push(24'd1024, 24'd1024); exp_push(24'd2048, 24'd1024);
        check_walk("t1");

        // 2: degenerate box
        send(24'd5120, 24'd3072, 24'd5120, 24'd3072, SS_1X, TRI_B, COL_B, 1'b0);
        exp_push(24'd5120, 24'd3072);
        check_walk("t2");

        // 3a: 4spp, rate input changed mid-walk must not matter
        send(24'd0, 24'd0, 24'd512, 24'd512, SS_4X, TRI_C, COL_C, 1'b0);
        sub_sample = SS_1X;
        exp_push(24'd0, 24'd0);   exp_push(24'd512, 24'd0);
        exp_push(24'd0, 24'd512); exp_push(24'd512, 24'd512);
        check_walk("t3a");

        // 3b: 64spp
        send(24'd0, 24'd0, 24'd128, 24'd0, SS_64X, TRI_A, COL_A, 1'b0);
        exp_push(24'd0, 24'd0); exp_push(24'd128, 24'd0);
        check_walk("t3b");

        // 3c: 16spp
        send(24'd0, 24'd0, 24'd256, 24'd0, SS_16X, TRI_B, COL_B, 1'b0);
        exp_push(24'd0, 24'd0); exp_push(24'd256, 24'd0);
        check_walk("t3c");

        // 3d: non-one-hot rate decodes as 1spp
        send(24'd0, 24'd0, 24'd1024, 24'd0, 4'b0110, TRI_C, COL_C, 1'b0);
        exp_push(24'd0, 24'd0); exp_push(24'd1024, 24'd0);
        check_walk("t3d");

        // 4: validTri held high across two triangles, one bubble between them
        send(24'd0, 24'd0, 24'd1024, 24'd0, SS_1X, TRI_A, COL_A, 1'b1);
        exp_push(24'd0, 24'd0); exp_push(24'd1024, 24'd0);
        check_walk("t4a");
        send(24'd2048, 24'd0, 24'd2048, 24'd0, SS_1X, TRI_B, COL_B, 1'b0);
        exp_push(24'd2048, 24'd0);
        check_walk("t4b");

        // 5: reset mid-walk of a 3x3 box, then restart at the new LL
        send(24'd0, 24'd0, 24'd2048, 24'd2048, SS_1X, TRI_C, COL_C, 1'b0);
        chk("t5_v0", valid_samp, 1'b1);
        chk("t5_x0", sample_out, {24'd0, 24'd0});
        @(negedge clk);
        chk("t5_v1", valid_samp, 1'b1);
        chk("t5_x1", sample_out, {24'd0, 24'd1024});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_valid", valid_samp, 1'b0);
        chk("t5_rst_halt", halt, 1'b1);
        chk("t5_rst_sample", sample_out, 48'h0);
        chk("t5_rst_tri", tri_out, 216'h0);
        chk("t5_rst_color", color_out, 72'h0);
        send(24'd3072, 24'd1024, 24'd4096, 24'd1024, SS_1X, TRI_A, COL_A, 1'b0);
        exp_push(24'd3072, 24'd1024); exp_push(24'd4096, 24'd1024);
        check_walk("t5b");

        // 6a: negative coordinates
        send(-24'sd1024, -24'sd1024, 24'd0, 24'd0, SS_1X, TRI_B, COL_B, 1'b0);
        exp_push(-24'sd1024, -24'sd1024); exp_push(24'd0, -24'sd1024);
        exp_push(-24'sd1024, 24'd0);      exp_push(24'd0, 24'd0);
        check_walk("t6a");

        // 6b: ur at the top of the signed range; the next step must not wrap
        send(24'h7FF800, 24'h7FFC00, 24'h7FFC00, 24'h7FFC00, SS_1X, TRI_C, COL_C, 1'b0);
        exp_push(24'h7FF800, 24'h7FFC00); exp_push(24'h7FFC00, 24'h7FFC00);
        check_walk("t6b");

        // Inverted box still emits the LL sample once
        send(24'd4096, 24'd4096, 24'd0, 24'd0, SS_1X, TRI_A, COL_A, 1'b0);
        exp_push(24'd4096, 24'd4096);
        check_walk("t7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
